// File: rtl/burst_sched_pkg.sv
// Shared types and helpers for the burst request scheduler and its arbiter.
package burst_sched_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   localparam int unsigned DEF_LEN_WIDTH = 3;
   typedef logic [DEF_LEN_WIDTH-1:0] beat_len_t;

   function automatic int unsigned src_idx_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant from the first requester at or after the
// priority pointer; the pointer moves past the winner when update_en is high.
module rr_arbiter
   import burst_sched_pkg::*;
#(
   parameter int unsigned NUM_REQUESTERS = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQUESTERS-1:0] req_bitmap,
   input  logic                      update_en,
   output logic [NUM_REQUESTERS-1:0] grant_oh
);

   localparam int unsigned SW = src_idx_width(NUM_REQUESTERS);

   logic [SW-1:0] ptr;
   logic [SW-1:0] grant_idx;

   always_comb begin
      int unsigned idx;
      logic        found;
      logic [SW-1:0] sel;
      grant_oh  = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      sel       = '0;
      for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
         idx = 32'(ptr) + i;
         if (idx >= NUM_REQUESTERS) idx = idx - NUM_REQUESTERS;
         sel = SW'(idx);
         if (!found && req_bitmap[sel]) begin
            grant_oh[sel] = 1'b1;
            grant_idx     = sel;
            found         = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (update_en) begin
         ptr <= (32'(grant_idx) == NUM_REQUESTERS - 1) ? '0 : SW'(32'(grant_idx) + 1);
      end
   end

endmodule

// File: rtl/burst_req_scheduler.sv
// Burst-holding round-robin scheduler sharing one downstream beat port.
// Optional perf counters enabled with `define BURST_SCHED_PERF_CNT_EN.
module burst_req_scheduler
   import burst_sched_pkg::*;
#(
   parameter int unsigned NUM_REQUESTERS = 4,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned LEN_WIDTH      = 3
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic [NUM_REQUESTERS-1:0]              req_valid_i,
   input  logic [NUM_REQUESTERS*LEN_WIDTH-1:0]    req_len_i,
   input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0]   req_data_i,
   output logic [NUM_REQUESTERS-1:0]              req_ready_o,
   output logic                                   out_valid_o,
   output logic [DATA_WIDTH-1:0]                  out_data_o,
   output logic                                   out_last_o,
   output logic [src_idx_width(NUM_REQUESTERS)-1:0] out_src_o,
`ifdef BURST_SCHED_PERF_CNT_EN
   output logic [31:0]                            perf_burst_cnt_o,
   output logic [31:0]                            perf_stall_cnt_o,
`endif
   input  logic                                   out_ready_i
);

   localparam int unsigned SW = src_idx_width(NUM_REQUESTERS);

   state_t                    state, state_d;
   logic [NUM_REQUESTERS-1:0] grant_q;
   logic [SW-1:0]             src_q;
   logic [LEN_WIDTH-1:0]      remaining;
   logic [NUM_REQUESTERS-1:0] arb_grant;
   logic [SW-1:0]             arb_idx;
   logic                      any_valid;
   logic                      update_en;
   logic                      beat_valid;
   logic                      xfer;

   function automatic logic [SW-1:0] oh2idx(input logic [NUM_REQUESTERS-1:0] oh);
      logic [SW-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
         if (oh[i]) r = r | SW'(i);
      end
      return r;
   endfunction

   assign any_valid = |req_valid_i;
   assign update_en = (state == IDLE) && any_valid;
   assign arb_idx   = oh2idx(arb_grant);

   rr_arbiter #(
      .NUM_REQUESTERS(NUM_REQUESTERS)
   ) u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_bitmap(req_valid_i),
      .update_en (update_en),
      .grant_oh  (arb_grant)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_d;
      end
   end

   always_comb begin
      state_d     = state;
      beat_valid  = 1'b0;
      out_data_o  = '0;
      req_ready_o = '0;
      out_last_o  = 1'b0;
      xfer        = 1'b0;
      case (state)
         IDLE: begin
            if (any_valid) state_d = BURST;
         end
         BURST: begin
            beat_valid  = req_valid_i[src_q];
            out_data_o  = req_data_i[32'(src_q)*DATA_WIDTH +: DATA_WIDTH];
            req_ready_o = grant_q & {NUM_REQUESTERS{out_ready_i}};
            out_last_o  = (remaining == '0) && beat_valid;
            xfer        = beat_valid && out_ready_i;
            if (xfer && (remaining == '0)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign out_valid_o = beat_valid;
   assign out_src_o   = src_q;

   // Length is captured only at grant; later changes on req_len_i are ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_q   <= '0;
         src_q     <= '0;
         remaining <= '0;
      end else if (update_en) begin
         grant_q   <= arb_grant;
         src_q     <= arb_idx;
         remaining <= req_len_i[32'(arb_idx)*LEN_WIDTH +: LEN_WIDTH];
      end else if (xfer && (remaining != '0)) begin
         remaining <= remaining - LEN_WIDTH'(1);
      end
   end

`ifdef BURST_SCHED_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_burst_cnt_o <= '0;
         perf_stall_cnt_o <= '0;
      end else begin
         if (xfer && out_last_o) perf_burst_cnt_o <= perf_burst_cnt_o + 32'd1;
         if ((state == BURST) && beat_valid && !out_ready_i)
            perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_burst_req_scheduler.sv
// Randomized bench for burst_req_scheduler against a transaction-rule model.
module tb_burst_req_scheduler;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int LW = 3;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [N-1:0]      req_valid;
   logic [N*LW-1:0]   req_len;
   logic [N*DW-1:0]   req_data;
   logic [N-1:0]      req_ready;
   logic              out_valid;
   logic [DW-1:0]     out_data;
   logic              out_last;
   logic [1:0]        out_src;
   logic              out_ready;
`ifdef BURST_SCHED_PERF_CNT_EN
   logic [31:0]       perf_burst_cnt;
   logic [31:0]       perf_stall_cnt;
`endif

   logic [LW-1:0] len_a [N];
   logic [DW-1:0] dat_a [N];

   always_comb begin
      for (int i = 0; i < N; i++) begin
         req_len[i*LW +: LW]  = len_a[i];
         req_data[i*DW +: DW] = dat_a[i];
      end
   end

   always #5 clk = ~clk;

   burst_req_scheduler #(
      .NUM_REQUESTERS(N),
      .DATA_WIDTH    (DW),
      .LEN_WIDTH     (LW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid_i(req_valid),
      .req_len_i  (req_len),
      .req_data_i (req_data),
      .req_ready_o(req_ready),
      .out_valid_o(out_valid),
      .out_data_o (out_data),
      .out_last_o (out_last),
      .out_src_o  (out_src),
`ifdef BURST_SCHED_PERF_CNT_EN
      .perf_burst_cnt_o(perf_burst_cnt),
      .perf_stall_cnt_o(perf_stall_cnt),
`endif
      .out_ready_i(out_ready)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Model: which requester owns the port, beats left, next round-robin start.
   bit          m_busy;
   int          m_owner, m_left, m_ptr, m_src;
   int unsigned m_bursts, m_stalls;
   bit          m_last;

   task automatic model_reset();
      m_busy = 0; m_owner = 0; m_left = 0; m_ptr = 0; m_src = 0;
      m_bursts = 0; m_stalls = 0; m_last = 0;
   endtask

   task automatic cycle_check();
      logic         ev, el;
      logic [N-1:0] erdy;
      ev = 0; el = 0; erdy = '0;
      if (m_busy) begin
         ev   = req_valid[m_owner];
         el   = ev && (m_left == 0);
         erdy = out_ready ? (N'(1) << m_owner) : '0;
         if (ev) check("out_data", out_data, dat_a[m_owner]);
      end
      m_last = el;
      check("out_valid", out_valid, ev);
      check("out_last", out_last, el);
      check("req_ready", req_ready, erdy);
      check("out_src", out_src, m_src);
`ifdef BURST_SCHED_PERF_CNT_EN
      check("perf_burst", perf_burst_cnt, m_bursts);
      check("perf_stall", perf_stall_cnt, m_stalls);
`endif
   endtask

   task automatic model_step();
      if (!m_busy) begin
         for (int i = 0; i < N; i++) begin
            int k;
            k = (m_ptr + i) % N;
            if (!m_busy && req_valid[k]) begin
               m_busy = 1; m_owner = k; m_src = k;
               m_left = int'(len_a[k]);
               m_ptr  = (k + 1) % N;
            end
         end
      end else if (req_valid[m_owner]) begin
         if (out_ready) begin
            if (m_left == 0) begin
               m_busy = 0;
               m_bursts++;
            end else begin
               m_left--;
            end
         end else begin
            m_stalls++;
         end
      end
   endtask

   task automatic drive(input int pv, input int pr);
      for (int i = 0; i < N; i++) begin
         req_valid[i] = ($urandom_range(99) < pv);
         len_a[i]     = LW'($urandom_range(7));
         dat_a[i]     = $urandom;
      end
      out_ready = ($urandom_range(99) < pr);
   endtask

   task automatic cycle();
      #1;
      cycle_check();
      if (rst_n) model_step();
   endtask

   initial begin
      int exp_seq;
      rst_n = 1'b0;
      req_valid = '0;
      out_ready = 1'b0;
      for (int i = 0; i < N; i++) begin
         len_a[i] = '0;
         dat_a[i] = '0;
      end
      model_reset();
      repeat (2) @(negedge clk);
      #1 cycle_check();

      // All valid, single-beat bursts: grants rotate 0,1,2,3,0.
      @(negedge clk);
      rst_n = 1'b1;
      exp_seq = 0;
      for (int c = 0; c < 10; c++) begin
         if (c != 0) @(negedge clk);
         req_valid = '1;
         out_ready = 1'b1;
         for (int i = 0; i < N; i++) begin
            len_a[i] = '0;
            dat_a[i] = $urandom;
         end
         cycle();
         if (m_last) begin
            check("rr_order", out_src, exp_seq % N);
            exp_seq++;
         end
      end
      check("rr_burst_count", exp_seq, 5);

      // Reset during beat 2 of a len=5 burst, then first grant returns to 0.
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         req_valid = '1;
         out_ready = 1'b1;
         for (int i = 0; i < N; i++) begin
            len_a[i] = LW'(5);
            dat_a[i] = $urandom;
         end
         cycle();
      end
      rst_n = 1'b0;
      model_reset();
      #1 cycle_check();
      check("rst_valid_zero", out_valid, 1'b0);
      check("rst_ready_zero", req_ready, '0);
      @(negedge clk);
      rst_n = 1'b1;
      cycle();
      @(negedge clk);
      cycle();
      check("post_rst_src", out_src, 0);

      // Random traffic with sporadic resets and back-pressure.
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         if (!rst_n) rst_n = 1'b1;
         drive((c / 500) % 2 ? 90 : 55, (c / 250) % 2 ? 60 : 90);
         if ($urandom_range(399) == 0) begin
            rst_n = 1'b0;
            model_reset();
         end
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
